// File: rtl/multi_vc_status_buffer_pkg.sv
// Shared types and defaults for the multi-VC router input buffer.
//   flit_label_t : HEAD / BODY / TAIL / HEADTAIL packet position
//   port_t       : routed output port
//   flit_t       : {label, vc, payload}
//   vc_state_t   : per-VC packet state (IDLE -> VA -> SA)
package multi_vc_status_buffer_pkg;

  localparam int NUM_VC_DEF        = 4;
  localparam int BUFFER_SIZE_DEF   = 8;
  localparam int ON_OFF_MARGIN_DEF = 2;
  localparam int VC_W              = $clog2(NUM_VC_DEF);
  localparam int PAYLOAD_W         = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_t;

  typedef struct packed {
    flit_label_t          label;
    logic [VC_W-1:0]      vc;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VA   = 2'd1,
    SA   = 2'd2
  } vc_state_t;

  // Opens a packet (HEAD or single-flit HEADTAIL).
  function automatic logic is_head(flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  // Closes a packet (TAIL or single-flit HEADTAIL).
  function automatic logic is_tail(flit_label_t l);
    return (l == TAIL) || (l == HEADTAIL);
  endfunction

endpackage

// File: rtl/multi_vc_status_buffer_if.sv
// Link/allocator-side bundle for the multi-VC input buffer.
//   master : upstream link + allocators (drive *_i, observe *_o)
//   slave  : the buffer itself
interface multi_vc_status_buffer_if #(
  parameter int NUM_VC = multi_vc_status_buffer_pkg::NUM_VC_DEF
);
  import multi_vc_status_buffer_pkg::*;

  logic                         wr_valid_i;
  flit_t                        wr_flit_i;
  port_t                        wr_port_i;
  logic [NUM_VC-1:0]            rd_i;
  logic [NUM_VC-1:0]            vc_grant_i;
  logic [NUM_VC-1:0][VC_W-1:0]  vc_new_i;

  flit_t [NUM_VC-1:0]           flit_o;
  port_t [NUM_VC-1:0]           port_o;
  logic [NUM_VC-1:0]            vc_req_o;
  logic [NUM_VC-1:0]            sw_req_o;
  logic [NUM_VC-1:0]            empty_o;
  logic [NUM_VC-1:0]            full_o;
  logic [NUM_VC-1:0]            on_off_o;
  logic [NUM_VC-1:0]            err_o;

  modport master (
    output wr_valid_i, wr_flit_i, wr_port_i, rd_i, vc_grant_i, vc_new_i,
    input  flit_o, port_o, vc_req_o, sw_req_o, empty_o, full_o, on_off_o, err_o
  );

  modport slave (
    input  wr_valid_i, wr_flit_i, wr_port_i, rd_i, vc_grant_i, vc_new_i,
    output flit_o, port_o, vc_req_o, sw_req_o, empty_o, full_o, on_off_o, err_o
  );

endinterface

// File: rtl/multi_vc_status_buffer_vc_flit_fifo.sv
// Single-VC circular flit FIFO with occupancy count.
//   clk, rst : clock, async active-high reset
//   push_i   : store data_i (caller guarantees not full)
//   pop_i    : drop head (caller guarantees not empty)
//   head_o   : flit at the read pointer
//   count_o  : occupancy, 0..DEPTH
module multi_vc_status_buffer_vc_flit_fifo
  import multi_vc_status_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  flit_t                    data_i,
  output flit_t                    head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  flit_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;

  // Power-of-two depth: pointers simply wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/multi_vc_status_buffer.sv
// Router input-port buffer with NUM_VC virtual channels, each with its own
// flit FIFO and packet FSM. Issues VC/switch allocation requests, stamps the
// granted downstream VC on outgoing flits and returns on/off backpressure.
//   clk, rst : clock, async active-high reset
//   vc_bus   : link/allocator bundle (slave side)
//
// state | meaning
// IDLE  | no packet; waiting for HEAD/HEADTAIL into an empty FIFO
// VA    | head stored; requesting a downstream VC
// SA    | downstream VC held; requesting the switch while flits are queued
module multi_vc_status_buffer
  import multi_vc_status_buffer_pkg::*;
#(
  parameter int NUM_VC        = NUM_VC_DEF,
  parameter int BUFFER_SIZE   = BUFFER_SIZE_DEF,
  parameter int ON_OFF_MARGIN = ON_OFF_MARGIN_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  multi_vc_status_buffer_if.slave   vc_bus
);

  localparam int CW = $clog2(BUFFER_SIZE) + 1;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_state_t        state_q, state_d;
    logic             tail_seen_q, tail_seen_d;
    logic             err_q, err_d;
    logic [VC_W-1:0]  down_vc_q, down_vc_d;
    port_t            port_q, port_d;

    logic [CW-1:0]    count;
    flit_t            head, stamped;
    logic             empty, full, wr_sel, label_ok, push, pop;

    multi_vc_status_buffer_vc_flit_fifo #(.DEPTH(BUFFER_SIZE)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (vc_bus.wr_flit_i),
      .head_o  (head),
      .count_o (count)
    );

    // Full is judged on the registered count, so a same-cycle pop never
    // makes room for a write.
    assign empty  = (count == '0);
    assign full   = (count == CW'(BUFFER_SIZE));
    assign wr_sel = vc_bus.wr_valid_i && (vc_bus.wr_flit_i.vc == VC_W'(v));

    always_comb begin
      state_d     = state_q;
      tail_seen_d = tail_seen_q;
      err_d       = err_q;
      down_vc_d   = down_vc_q;
      port_d      = port_q;
      label_ok    = 1'b0;
      pop         = 1'b0;

      case (state_q)
        IDLE:    label_ok = is_head(vc_bus.wr_flit_i.label) && empty;
        VA, SA:  label_ok = !is_head(vc_bus.wr_flit_i.label);
        default: label_ok = 1'b0;
      endcase

      // Only one packet per VC may be in flight: nothing after its tail.
      push = wr_sel && !full && label_ok && !tail_seen_q;
      if (wr_sel && !push) err_d = 1'b1;
      if (push && is_tail(vc_bus.wr_flit_i.label)) tail_seen_d = 1'b1;

      case (state_q)
        IDLE: begin
          if (push) begin
            port_d  = port_t'(vc_bus.wr_port_i);
            state_d = VA;
          end
          if (vc_bus.vc_grant_i[v] || vc_bus.rd_i[v]) err_d = 1'b1;
        end
        VA: begin
          if (vc_bus.vc_grant_i[v]) begin
            down_vc_d = vc_bus.vc_new_i[v];
            state_d   = SA;
          end
          if (vc_bus.rd_i[v]) err_d = 1'b1;
        end
        SA: begin
          if (vc_bus.vc_grant_i[v]) err_d = 1'b1;
          if (vc_bus.rd_i[v]) begin
            if (empty) begin
              err_d = 1'b1;
            end else begin
              pop = 1'b1;
              if (is_tail(head.label)) begin
                state_d     = IDLE;
                tail_seen_d = 1'b0;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q     <= IDLE;
        tail_seen_q <= 1'b0;
        err_q       <= 1'b0;
        down_vc_q   <= '0;
        port_q      <= LOCAL;
      end else begin
        state_q     <= state_d;
        tail_seen_q <= tail_seen_d;
        err_q       <= err_d;
        down_vc_q   <= down_vc_d;
        port_q      <= port_d;
      end
    end

    always_comb begin
      stamped    = head;
      stamped.vc = down_vc_q;
    end

    // Gating with empty keeps flit_o at zero out of reset even though the
    // storage array itself is not reset.
    assign vc_bus.flit_o[v]   = empty ? flit_t'('0) : stamped;
    assign vc_bus.port_o[v]   = port_q;
    assign vc_bus.vc_req_o[v] = (state_q == VA);
    assign vc_bus.sw_req_o[v] = (state_q == SA) && !empty;
    assign vc_bus.empty_o[v]  = empty;
    assign vc_bus.full_o[v]   = full;
    assign vc_bus.on_off_o[v] = (count >= CW'(BUFFER_SIZE - ON_OFF_MARGIN));
    assign vc_bus.err_o[v]    = err_q;
  end

endmodule

// File: tb/tb_multi_vc_status_buffer.sv
module tb_multi_vc_status_buffer;
  import multi_vc_status_buffer_pkg::*;

  localparam int NV     = NUM_VC_DEF;
  localparam int BS     = BUFFER_SIZE_DEF;
  localparam int MARGIN = ON_OFF_MARGIN_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_vc_status_buffer_if #(.NUM_VC(NV)) vif ();

  multi_vc_status_buffer #(
    .NUM_VC(NV), .BUFFER_SIZE(BS), .ON_OFF_MARGIN(MARGIN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .vc_bus (vif)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // ---------------- reference model: queues per VC ----------------
  flit_t           mq     [NV][$];
  int              mstate [NV];     // 0 idle, 1 waiting VC, 2 waiting switch
  bit              mtail  [NV];
  port_t           mport  [NV];
  logic [VC_W-1:0] mdvc   [NV];
  bit              merr   [NV];

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      mstate[v] = 0;
      mtail[v]  = 1'b0;
      mport[v]  = LOCAL;
      mdvc[v]   = '0;
      merr[v]   = 1'b0;
    end
  endtask

  task automatic model_step();
    bit          wsel, headish, legal, acc, rdv, grv;
    int          nstate;
    flit_t       f;
    flit_label_t lb;
    for (int v = 0; v < NV; v++) begin
      wsel    = vif.wr_valid_i && (int'(vif.wr_flit_i.vc) == v);
      lb      = vif.wr_flit_i.label;
      headish = (lb == HEAD) || (lb == HEADTAIL);
      legal   = (mstate[v] == 0) ? (headish && mq[v].size() == 0) : !headish;
      acc     = wsel && (mq[v].size() < BS) && legal && !mtail[v];
      rdv     = vif.rd_i[v];
      grv     = vif.vc_grant_i[v];
      nstate  = mstate[v];
      if (wsel && !acc) merr[v] = 1'b1;
      if (mstate[v] == 0 && (grv || rdv)) merr[v] = 1'b1;
      if (mstate[v] == 1 && rdv) merr[v] = 1'b1;
      if (mstate[v] == 2 && grv) merr[v] = 1'b1;
      if (mstate[v] == 2 && rdv && mq[v].size() == 0) merr[v] = 1'b1;
      if (mstate[v] == 2 && rdv && mq[v].size() > 0) begin
        f = mq[v].pop_front();
        if (f.label == TAIL || f.label == HEADTAIL) begin
          nstate   = 0;
          mtail[v] = 1'b0;
        end
      end
      if (mstate[v] == 1 && grv) begin
        mdvc[v] = vif.vc_new_i[v];
        nstate  = 2;
      end
      if (acc) begin
        mq[v].push_back(vif.wr_flit_i);
        if (lb == TAIL || lb == HEADTAIL) mtail[v] = 1'b1;
        if (mstate[v] == 0) begin
          mport[v] = vif.wr_port_i;
          nstate   = 1;
        end
      end
      mstate[v] = nstate;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int v = 0; v < NV; v++) begin
        flit_t ef;
        ef = '0;
        if (mq[v].size() > 0) begin
          ef    = mq[v][0];
          ef.vc = mdvc[v];
        end
        chk($sformatf("flit_o[%0d]", v),   vif.flit_o[v],   ef);
        chk($sformatf("port_o[%0d]", v),   vif.port_o[v],   mport[v]);
        chk($sformatf("vc_req_o[%0d]", v), vif.vc_req_o[v], mstate[v] == 1);
        chk($sformatf("sw_req_o[%0d]", v), vif.sw_req_o[v], mstate[v] == 2 && mq[v].size() > 0);
        chk($sformatf("empty_o[%0d]", v),  vif.empty_o[v],  mq[v].size() == 0);
        chk($sformatf("full_o[%0d]", v),   vif.full_o[v],   mq[v].size() == BS);
        chk($sformatf("on_off_o[%0d]", v), vif.on_off_o[v], mq[v].size() >= BS - MARGIN);
        chk($sformatf("err_o[%0d]", v),    vif.err_o[v],    merr[v]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    vif.wr_valid_i = 1'b0;
    vif.wr_flit_i  = '0;
    vif.wr_port_i  = LOCAL;
    vif.rd_i       = '0;
    vif.vc_grant_i = '0;
    vif.vc_new_i   = '0;
  endtask

  function automatic flit_t mk(flit_label_t l, int vc, int pl);
    flit_t f;
    f.label   = l;
    f.vc      = VC_W'(vc);
    f.payload = PAYLOAD_W'(pl);
    return f;
  endfunction

  task automatic tick(input logic wv, input flit_t f, input port_t p,
                      input logic [NV-1:0] rd, input logic [NV-1:0] gr,
                      input logic [NV-1:0][VC_W-1:0] vn);
    vif.wr_valid_i = wv;
    vif.wr_flit_i  = f;
    vif.wr_port_i  = p;
    vif.rd_i       = rd;
    vif.vc_grant_i = gr;
    vif.vc_new_i   = vn;
    @(negedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic wr(input flit_label_t l, input int vc, input int pl, input port_t p);
    tick(1'b1, mk(l, vc, pl), p, '0, '0, '0);
  endtask

  task automatic rdv(input logic [NV-1:0] m);
    tick(1'b0, '0, LOCAL, m, '0, '0);
  endtask

  task automatic grant(input int v, input int nv);
    logic [NV-1:0]           g;
    logic [NV-1:0][VC_W-1:0] n;
    g    = '0;
    n    = '0;
    g[v] = 1'b1;
    n[v] = VC_W'(nv);
    tick(1'b0, '0, LOCAL, '0, g, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [NV-1:0]           rd, gr;
    logic [NV-1:0][VC_W-1:0] vn;
    flit_label_t             lb;
    logic                    wv;
    int                      v, r;

    idle_inputs();
    model_reset();
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;

    chk("rst_empty",  vif.empty_o,  4'hF);
    chk("rst_full",   vif.full_o,   4'h0);
    chk("rst_onoff",  vif.on_off_o, 4'h0);
    chk("rst_reqs",   {vif.vc_req_o, vif.sw_req_o}, 8'h00);
    chk("rst_err",    vif.err_o,    4'h0);
    chk("rst_flit",   vif.flit_o,   '0);

    // single-flit packet on VC2
    wr(HEADTAIL, 2, 'hA5, EAST);
    chk("ht_vcreq", vif.vc_req_o, 4'b0100);
    chk("ht_port",  vif.port_o[2], EAST);
    grant(2, 3);
    chk("ht_swreq", vif.sw_req_o, 4'b0100);
    chk("ht_stamp", vif.flit_o[2].vc, 3);
    chk("ht_pay",   vif.flit_o[2].payload, 'hA5);
    rdv(4'b0100);
    chk("ht_empty", vif.empty_o, 4'hF);
    chk("ht_reqs",  {vif.vc_req_o, vif.sw_req_o}, 8'h00);
    chk("ht_err",   vif.err_o, 4'h0);

    // VC1 fills to the brim
    wr(HEAD, 1, 1, NORTH);
    chk("v1_onoff_1", vif.on_off_o[1], 1'b0);
    for (int k = 1; k <= 6; k++) begin
      wr(BODY, 1, 1 + k, NORTH);
      chk($sformatf("v1_onoff_%0d", k + 1), vif.on_off_o[1], (k + 1) >= 6);
      chk($sformatf("v1_full_%0d", k + 1),  vif.full_o[1], 1'b0);
    end
    wr(TAIL, 1, 8, NORTH);
    chk("v1_full_8", vif.full_o[1], 1'b1);
    wr(BODY, 1, 9, NORTH);
    chk("v1_err9",   vif.err_o, 4'b0010);
    chk("v1_full_9", vif.full_o[1], 1'b1);
    grant(1, 2);
    chk("v1_head",   vif.flit_o[1].payload, 1);
    for (int k = 0; k < 8; k++) rdv(4'b0010);
    chk("v1_drained", {vif.empty_o[1], vif.vc_req_o[1], vif.sw_req_o[1]}, 3'b100);
    do_reset();

    // VC0: same-cycle read+write at count 7 across pointer wrap
    wr(HEAD, 0, 'h10, SOUTH);
    wr(BODY, 0, 'h11, SOUTH);
    wr(TAIL, 0, 'h12, SOUTH);
    grant(0, 1);
    repeat (3) rdv(4'b0001);
    wr(HEAD, 0, 'h20, WEST);
    for (int k = 1; k <= 6; k++) wr(BODY, 0, 'h20 + k, WEST);
    grant(0, 2);
    chk("v0_onoff7", vif.on_off_o[0], 1'b1);
    tick(1'b1, mk(BODY, 0, 'h27), LOCAL, 4'b0001, '0, '0);
    chk("v0_rw_full", vif.full_o[0], 1'b0);
    chk("v0_rw_head", vif.flit_o[0].payload, 'h21);
    wr(TAIL, 0, 'h28, WEST);
    chk("v0_full8", vif.full_o[0], 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("v0_order_%0d", k), vif.flit_o[0].payload, 'h21 + k);
      rdv(4'b0001);
    end
    chk("v0_done_err", vif.err_o, 4'h0);

    // each protocol error flags only its own VC
    do_reset();
    wr(BODY, 3, 1, LOCAL);
    chk("err_body_idle", vif.err_o, 4'b1000);
    do_reset();
    rdv(4'b1000);
    chk("err_rd_empty", vif.err_o, 4'b1000);
    do_reset();
    wr(HEAD, 1, 1, EAST);
    wr(HEAD, 1, 2, EAST);
    chk("err_head_va", vif.err_o, 4'b0010);
    do_reset();
    wr(HEADTAIL, 0, 'h55, EAST);
    wr(BODY, 0, 'h56, EAST);
    chk("err_after_tail", vif.err_o, 4'b0001);
    chk("err_dropped",    vif.flit_o[0].payload, 'h55);
    do_reset();

    // interleaved VC0 / VC3 packets with staggered grants
    wr(HEAD, 0, 'h30, WEST);
    wr(HEAD, 3, 'h40, SOUTH);
    wr(BODY, 0, 'h31, WEST);
    wr(BODY, 3, 'h41, SOUTH);
    grant(3, 1);
    wr(BODY, 0, 'h32, WEST);
    wr(TAIL, 3, 'h42, SOUTH);
    grant(0, 2);
    wr(TAIL, 0, 'h33, WEST);
    chk("il_stamp3", vif.flit_o[3].vc, 1);
    chk("il_stamp0", vif.flit_o[0].vc, 2);
    chk("il_port0",  vif.port_o[0], WEST);
    chk("il_port3",  vif.port_o[3], SOUTH);
    repeat (3) rdv(4'b1001);
    chk("il_v3_idle", {vif.empty_o[3], vif.sw_req_o[3], vif.vc_req_o[3]}, 3'b100);
    chk("il_v0_last", vif.flit_o[0].payload, 'h33);
    rdv(4'b0001);
    chk("il_done", {vif.empty_o, vif.sw_req_o, vif.vc_req_o, vif.err_o}, 16'hF000);

    // asynchronous reset while VC2 holds four flits in SA
    wr(HEAD, 2, 'h60, NORTH);
    for (int k = 1; k <= 3; k++) wr(BODY, 2, 'h60 + k, NORTH);
    grant(2, 1);
    chk("ar_pre_sw", vif.sw_req_o, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_empty", vif.empty_o,  4'hF);
    chk("ar_full",  vif.full_o,   4'h0);
    chk("ar_onoff", vif.on_off_o, 4'h0);
    chk("ar_reqs",  {vif.vc_req_o, vif.sw_req_o}, 8'h00);
    chk("ar_err",   vif.err_o,    4'h0);
    chk("ar_port",  vif.port_o,   '0);
    chk("ar_flit",  vif.flit_o,   '0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    wr(HEAD, 2, 'h70, EAST);
    chk("ar_head_err",   vif.err_o, 4'h0);
    chk("ar_head_vcreq", vif.vc_req_o, 4'b0100);

    // randomized traffic biased toward legal packets
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 299) begin
        do_reset();
        continue;
      end
      v = $urandom_range(NV - 1);
      r = $urandom_range(99);
      if (mstate[v] == 0)
        lb = (r < 60) ? HEAD : (r < 90) ? HEADTAIL : (r < 95) ? BODY : TAIL;
      else
        lb = (r < 70) ? BODY : (r < 90) ? TAIL : (r < 95) ? HEAD : HEADTAIL;
      wv = ($urandom_range(99) < 70);
      if ((mtail[v] || mq[v].size() == BS) && $urandom_range(99) < 90) wv = 1'b0;
      for (int u = 0; u < NV; u++) begin
        gr[u] = (mstate[u] == 1) ? ($urandom_range(99) < 40) : ($urandom_range(199) == 0);
        rd[u] = (mstate[u] == 2 && mq[u].size() > 0) ? ($urandom_range(99) < 35)
                                                     : ($urandom_range(199) == 0);
        vn[u] = VC_W'($urandom_range(NV - 1));
      end
      tick(wv, mk(lb, v, $urandom_range(16'hFFFF)), port_t'($urandom_range(4)), rd, gr, vn);
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
